cpu_sram_responder: RTL and testbench
=====================================

Name: cpu_sram_responder

Overview:
Responder end of the core's instruction/data SRAM interfaces. It is a synchronous, dual-port, word-organised RAM with byte write enables and a fixed 1-cycle read latency. The data port also decodes a small MMIO window holding a free-running timer, a compare/interrupt register, LEDs and switches. It sits at the SoC top level beside the core and serves both the fetch and load/store paths.

Parameters:
ADDR_W, 14, RAM depth is 2^ADDR_W 32-bit words, indexed by addr[ADDR_W+1:2]
MMIO_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO window (data port only)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  reset, asynchronous, active-high
inst_sram_en  input  1  instruction port access enable
inst_sram_wen  input  4  instruction port byte write enables
inst_sram_addr  input  32  instruction port byte address
inst_sram_wdata  input  32  instruction port write data
inst_sram_rdata  output  32  instruction port read data, registered
data_sram_en  input  1  data port access enable
data_sram_wen  input  4  data port byte write enables
data_sram_addr  input  32  data port byte address
data_sram_wdata  input  32  data port write data
data_sram_rdata  output  32  data port read data, registered
switch  input  8  board switches, sampled combinationally on MMIO read
led  output  16  LED register
timer_irq  output  1  timer interrupt pending flag, level

Behaviour:
- Reset: inst_sram_rdata=0, data_sram_rdata=0, led=0, counter=0, compare=0, pending=0, timer_irq=0.
- RAM contents are not reset. Reset asserted mid-access discards the access, and rdata reads 0 after release.
- en=0 on a port: no write regardless of wen; that port's rdata holds its previous value.
- Read latency: with en=1 at edge N, rdata is valid after edge N and holds until the next enabled edge on that port.
- Reads are read-first: a same-port or cross-port read and write to the same word in one cycle returns the old word.
- Byte writes: wen[i]=1 writes wdata[8i+7:8i] into byte lane i of the addressed word. Address bits [1:0] and bits above ADDR_W+1 are ignored for RAM indexing.
- Dual write conflict (same word, same cycle): the data port wins per byte lane; inst-port lanes not written by the data port still take effect.
- MMIO window applies when data_sram_addr[31:16]==MMIO_HI. The RAM is neither read nor written for these accesses. Offsets come from addr[15:0]:
  - 0x0000 counter: RW, byte-enable writes.
  - 0x0004 compare: RW, byte-enable writes.
  - 0x0008 led: RW, low 16 bits; writes use wen[1:0] only; reads are zero-extended.
  - 0x000C switch: RO, zero-extended; writes ignored.
  - 0x0010 status: bit0=pending; writing 1 to bit0 (wen[0]=1) clears it; other bits read 0.
  - Any other offset reads 0 and ignores writes.
- The inst port does not decode MMIO. An inst read in the window returns 0, with no side effects and no RAM write.
- Timer counter:
  - Increments by 1 every cycle, wrapping from 32'hFFFFFFFF to 0.
  - An MMIO write to the counter loads the merged written value, with no increment that cycle.
- Interrupt:
  - pending sets at the edge where counter==compare and compare!=0, using pre-increment values.
  - If set and clear occur in the same cycle, set wins.
  - timer_irq = pending, registered.
- A write to compare does not by itself set pending; the match is evaluated against the old compare in that cycle.

Test Plan:
- Byte write/read: data port writes 0x11223344 to word 0x10 with wen=4'b1111, then wen=4'b0010 with wdata=0x0000AA00; a read the next cycle returns 0x1122AA44 one edge after the enable.
- Read-first and conflict: in one cycle, inst reads word 5 (holding 0xDEADBEEF) while data writes 0x0 to word 5 → inst_sram_rdata=0xDEADBEEF. Dual writes to word 6 (inst 0xFFFFFFFF wen=1111, data 0x00000000 wen=0011) → word 6 = 0xFFFF0000.
- Timer interrupt: write compare=20 and counter=0 at cycle T → timer_irq rises 21 cycles later. Writing status=1 drops it next edge. A clear coinciding with a new match keeps timer_irq=1.
- Counter wrap and load: write counter=0xFFFFFFFE, then read twice on consecutive cycles → observes the wrap to 0x00000000. A counter write in the same cycle as an increment loads exactly the written value.
- MMIO misc:
  - led write 0x0001A5A5 with wen=1111 → led=0xA5A5.
  - switch=8'h3C → read of offset 0xC returns 0x0000003C.
  - Offset 0x20 read returns 0.
  - inst port read at 0xBFAF0008 returns 0.
- Reset/enable: assert rst mid-read → both rdata=0 and led=0 immediately (asynchronous). After release, en=0 with wen=1111 leaves RAM unchanged and rdata held.

Source files
------------

// File: rtl/cpu_sram_responder.sv
// Dual-port word RAM with byte write enables and a one-cycle registered read,
// plus a small MMIO window on the data port (timer, compare/irq, LEDs, switches).
module cpu_sram_responder #(
    parameter int          ADDR_W  = 14,
    parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic        timer_irq
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [15:0] OFF_COUNTER = 16'h0000;
    localparam logic [15:0] OFF_COMPARE = 16'h0004;
    localparam logic [15:0] OFF_LED     = 16'h0008;
    localparam logic [15:0] OFF_SWITCH  = 16'h000C;
    localparam logic [15:0] OFF_STATUS  = 16'h0010;

    logic [31:0] mem [DEPTH];

    logic [31:0] counter;
    logic [31:0] compare;
    logic        pending;

    logic              inst_win;
    logic              data_win;
    logic [ADDR_W-1:0] inst_idx;
    logic [ADDR_W-1:0] data_idx;
    logic [3:0]        inst_lane_we;
    logic [3:0]        data_lane_we;
    logic [15:0]       offset;
    logic              mmio_wr;
    logic              cnt_wr;
    logic              cmp_wr;
    logic              led_wr;
    logic              status_clr;
    logic              match;
    logic [31:0]       mmio_rdata;
    logic              unused_addr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign inst_win = (inst_sram_addr[31:16] == MMIO_HI);
    assign data_win = (data_sram_addr[31:16] == MMIO_HI);
    assign inst_idx = inst_sram_addr[ADDR_W+1:2];
    assign data_idx = data_sram_addr[ADDR_W+1:2];
    assign offset   = data_sram_addr[15:0];

    // A reset edge discards any in-flight RAM write; window accesses never touch the RAM.
    assign inst_lane_we = (inst_sram_en && !inst_win && !rst) ? inst_sram_wen : 4'b0000;
    assign data_lane_we = (data_sram_en && !data_win && !rst) ? data_sram_wen : 4'b0000;

    assign mmio_wr    = data_sram_en && data_win && (|data_sram_wen);
    assign cnt_wr     = mmio_wr && (offset == OFF_COUNTER);
    assign cmp_wr     = mmio_wr && (offset == OFF_COMPARE);
    assign led_wr     = mmio_wr && (offset == OFF_LED) && (|data_sram_wen[1:0]);
    assign status_clr = mmio_wr && (offset == OFF_STATUS) && data_sram_wen[0] && data_sram_wdata[0];
    assign match      = (counter == compare) && (compare != 32'd0);

    assign timer_irq        = pending;
    assign unused_addr_bits = ^inst_sram_addr[1:0];

    // MMIO read mux; register values are the pre-edge ones.
    always_comb begin
        mmio_rdata = 32'd0;
        case (offset)
            OFF_COUNTER: mmio_rdata = counter;
            OFF_COMPARE: mmio_rdata = compare;
            OFF_LED:     mmio_rdata = {16'd0, led};
            OFF_SWITCH:  mmio_rdata = {24'd0, switch};
            OFF_STATUS:  mmio_rdata = {31'd0, pending};
            default:     mmio_rdata = 32'd0;
        endcase
    end

    // RAM byte-lane writes; data port is applied second so it wins a shared lane.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (inst_lane_we[i]) mem[inst_idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
            if (data_lane_we[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
    end

    // Registered read ports, read-first; a disabled port holds its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_sram_rdata <= 32'd0;
            data_sram_rdata <= 32'd0;
        end else begin
            if (inst_sram_en) inst_sram_rdata <= inst_win ? 32'd0 : mem[inst_idx];
            if (data_sram_en) data_sram_rdata <= data_win ? mmio_rdata : mem[data_idx];
        end
    end

    // Timer, compare, LED and interrupt-pending registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= 32'd0;
            compare <= 32'd0;
            led     <= 16'd0;
            pending <= 1'b0;
        end else begin
            if (cnt_wr) counter <= merge_bytes(counter, data_sram_wdata, data_sram_wen);
            else        counter <= counter + 32'd1;
            if (cmp_wr) compare <= merge_bytes(compare, data_sram_wdata, data_sram_wen);
            if (led_wr) begin
                if (data_sram_wen[0]) led[7:0]  <= data_sram_wdata[7:0];
                if (data_sram_wen[1]) led[15:8] <= data_sram_wdata[15:8];
            end
            if (match)           pending <= 1'b1;
            else if (status_clr) pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sram_responder.sv
module tb_cpu_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_sram_en = 1'b0;
    logic [3:0]  inst_sram_wen = 4'd0;
    logic [31:0] inst_sram_addr = 32'd0;
    logic [31:0] inst_sram_wdata = 32'd0;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'd0;
    logic [31:0] data_sram_addr = 32'd0;
    logic [31:0] data_sram_wdata = 32'd0;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch = 8'd0;
    logic [15:0] led;
    logic        timer_irq;

    cpu_sram_responder dut (
        .clk            (clk),
        .rst            (rst),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .switch         (switch),
        .led            (led),
        .timer_irq      (timer_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] mem_m [int];
    logic [31:0] m_cnt, m_cmp;
    logic [15:0] m_led;
    logic        m_pend;
    logic [31:0] exp_i, exp_d;
    logic        exp_i_v, exp_d_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'd16384);
    endfunction

    function automatic logic [31:0] m_mmio_rd(input logic [15:0] off);
        case (off)
            16'h0000: return m_cnt;
            16'h0004: return m_cmp;
            16'h0008: return {16'd0, m_led};
            16'h000C: return {24'd0, switch};
            16'h0010: return {31'd0, m_pend};
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_cmp = 0; m_led = 0; m_pend = 0;
        exp_i = 0; exp_d = 0; exp_i_v = 1; exp_d_v = 1;
    endtask

    // Apply one clock edge's worth of behaviour to the model, from the current inputs.
    task automatic model_edge();
        logic iwin, dwin, hit, clr, wr;
        logic [15:0] off;
        int ii, di;
        if (rst) begin model_reset(); return; end
        iwin = inst_sram_addr[31:16] == 16'hBFAF;
        dwin = data_sram_addr[31:16] == 16'hBFAF;
        ii = widx(inst_sram_addr);
        di = widx(data_sram_addr);
        off = data_sram_addr[15:0];
        if (inst_sram_en) begin
            if (iwin) begin exp_i = 0; exp_i_v = 1; end
            else if (mem_m.exists(ii)) begin exp_i = mem_m[ii]; exp_i_v = 1; end
            else exp_i_v = 0;
        end
        if (data_sram_en) begin
            if (dwin) begin exp_d = m_mmio_rd(off); exp_d_v = 1; end
            else if (mem_m.exists(di)) begin exp_d = mem_m[di]; exp_d_v = 1; end
            else exp_d_v = 0;
        end
        if (inst_sram_en && !iwin && inst_sram_wen != 0)
            mem_m[ii] = bmerge(mem_m.exists(ii) ? mem_m[ii] : 32'd0, inst_sram_wdata, inst_sram_wen);
        if (data_sram_en && !dwin && data_sram_wen != 0)
            mem_m[di] = bmerge(mem_m.exists(di) ? mem_m[di] : 32'd0, data_sram_wdata, data_sram_wen);
        hit = (m_cnt == m_cmp) && (m_cmp != 0);
        wr  = data_sram_en && dwin && (data_sram_wen != 0);
        clr = wr && off == 16'h0010 && data_sram_wen[0] && data_sram_wdata[0];
        if (wr && off == 16'h0000) m_cnt = bmerge(m_cnt, data_sram_wdata, data_sram_wen);
        else m_cnt = m_cnt + 1;
        if (wr && off == 16'h0004) m_cmp = bmerge(m_cmp, data_sram_wdata, data_sram_wen);
        if (wr && off == 16'h0008) begin
            if (data_sram_wen[0]) m_led[7:0]  = data_sram_wdata[7:0];
            if (data_sram_wen[1]) m_led[15:8] = data_sram_wdata[15:8];
        end
        if (hit) m_pend = 1;
        else if (clr) m_pend = 0;
    endtask

    task automatic check_outputs();
        if (exp_i_v) chk("inst_rdata", inst_sram_rdata, exp_i);
        if (exp_d_v) chk("data_rdata", data_sram_rdata, exp_d);
        chk("led", {16'd0, led}, {16'd0, m_led});
        chk("timer_irq", {31'd0, timer_irq}, {31'd0, m_pend});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic cyc(input logic ie, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] id,
                       input logic de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia; inst_sram_wdata = id;
        data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
        step();
    endtask

    task automatic dwr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        cyc(0, 0, 0, 0, 1, w, a, d);
    endtask

    task automatic drd(input logic [31:0] a);
        cyc(0, 0, 0, 0, 1, 0, a, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        logic [31:0] a, d;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // give the 32 words the bench uses a known value
        for (int w = 0; w < 32; w++) dwr(w * 4, $urandom, 4'b1111);

        // byte write then read back
        dwr(32'h40, 32'h11223344, 4'b1111);
        dwr(32'h40, 32'h0000AA00, 4'b0010);
        drd(32'h40);
        chk("byte_merge", data_sram_rdata, 32'h1122AA44);

        // read-first across ports
        dwr(32'h14, 32'hDEADBEEF, 4'b1111);
        cyc(1, 4'b0000, 32'h14, 0, 1, 4'b1111, 32'h14, 32'h0);
        chk("read_first", inst_sram_rdata, 32'hDEADBEEF);
        cyc(1, 4'b1111, 32'h18, 32'hFFFFFFFF, 1, 4'b0011, 32'h18, 32'h0);
        drd(32'h18);
        chk("dual_write", data_sram_rdata, 32'hFFFF0000);

        // MMIO misc
        dwr(32'hBFAF0008, 32'h0001A5A5, 4'b1111);
        chk("led_write", {16'd0, led}, 32'h0000A5A5);
        switch = 8'h3C;
        drd(32'hBFAF000C);
        chk("switch_rd", data_sram_rdata, 32'h0000003C);
        drd(32'hBFAF0020);
        chk("off20_rd", data_sram_rdata, 32'h0);
        cyc(1, 4'b1111, 32'hBFAF0008, 32'h12345678, 0, 0, 0, 0);
        chk("inst_win_rd", inst_sram_rdata, 32'h0);

        // timer interrupt
        dwr(32'hBFAF0004, 32'd20, 4'b1111);
        dwr(32'hBFAF0000, 32'd0, 4'b1111);
        n = 0;
        while (!timer_irq && n < 40) begin idle(); n++; end
        chk("irq_latency", n, 21);
        dwr(32'hBFAF0010, 32'h1, 4'b0001);
        chk("irq_clear", {31'd0, timer_irq}, 32'h0);
        dwr(32'hBFAF0000, 32'd18, 4'b1111);
        idle();
        idle();
        dwr(32'hBFAF0010, 32'h1, 4'b0001);
        chk("set_beats_clr", {31'd0, timer_irq}, 32'h1);

        // counter wrap and load
        dwr(32'hBFAF0000, 32'hFFFFFFFE, 4'b1111);
        drd(32'hBFAF0000);
        chk("cnt_rd0", data_sram_rdata, 32'hFFFFFFFE);
        drd(32'hBFAF0000);
        chk("cnt_rd1", data_sram_rdata, 32'hFFFFFFFF);
        drd(32'hBFAF0000);
        chk("cnt_wrap", data_sram_rdata, 32'h0);
        dwr(32'hBFAF0000, 32'h12345678, 4'b1111);
        drd(32'hBFAF0000);
        chk("cnt_load", data_sram_rdata, 32'h12345678);

        // randomized mixed traffic
        for (int c = 0; c < 400; c++) begin
            logic ie, de;
            logic [3:0] iw, dw;
            logic [31:0] ia, da;
            logic [15:0] hi;
            ie = $urandom_range(3) != 0;
            de = $urandom_range(3) != 0;
            iw = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
            dw = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
            hi = 16'($urandom);
            if (hi == 16'hBFAF) hi = 16'h0000;
            ia = {hi, 9'd0, 5'($urandom), 2'($urandom)};
            if ($urandom_range(15) == 0) ia = {16'hBFAF, 16'($urandom)};
            hi = 16'($urandom);
            if (hi == 16'hBFAF) hi = 16'h0001;
            da = {hi, 9'd0, 5'($urandom), 2'($urandom)};
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(7))
                    0: da = 32'hBFAF0000;
                    1: da = 32'hBFAF0004;
                    2: da = 32'hBFAF0008;
                    3: da = 32'hBFAF000C;
                    4: da = 32'hBFAF0010;
                    5: da = 32'hBFAF0020;
                    6: da = 32'hBFAF0014;
                    default: da = {16'hBFAF, 16'($urandom)};
                endcase
            end
            switch = 8'($urandom);
            cyc(ie, iw, ia, $urandom, de, dw, da, $urandom);
        end

        // asynchronous reset in the middle of a read
        dwr(32'h0C, 32'hCAFEF00D, 4'b1111);
        inst_sram_en = 1; inst_sram_wen = 0; inst_sram_addr = 32'h0C;
        data_sram_en = 1; data_sram_wen = 0; data_sram_addr = 32'h0C;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_inst_rdata", inst_sram_rdata, 32'h0);
        chk("rst_data_rdata", data_sram_rdata, 32'h0);
        chk("rst_led", {16'd0, led}, 32'h0);
        step();
        rst = 1'b0;
        idle();
        a = 32'h0C;
        d = 32'h5555AAAA;
        cyc(0, 4'b1111, a, d, 0, 4'b1111, a, d);
        chk("en0_hold", data_sram_rdata, 32'h0);
        drd(a);
        chk("en0_no_write", data_sram_rdata, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // safety net against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
